// File: rtl/sqrt_err_stats.sv
// Per-frame statistics over (sample, sqrt error) pairs: error sum, max error
// with its sample, exact-square count and sample count, on a valid/ready port.
module sqrt_err_stats #(
  parameter int ASIZE     = 8,
  parameter int ESIZE     = 8,
  parameter int FRAME_LEN = 16,
  localparam int CW = $clog2(FRAME_LEN + 1),
  localparam int SW = ESIZE + $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ASIZE-1:0] in_a,
  input  logic [ESIZE-1:0] in_err,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SW-1:0]    sum_err,
  output logic [ESIZE-1:0] max_err,
  output logic [ASIZE-1:0] max_err_a,
  output logic [CW-1:0]    exact_cnt,
  output logic [CW-1:0]    frame_cnt
);

  localparam logic [0:0] S_ACCUM = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             ov_q, ov_d;
  logic [SW-1:0]    sum_q, sum_d;
  logic [ESIZE-1:0] max_q, max_d;
  logic [ASIZE-1:0] maxa_q, maxa_d;
  logic [CW-1:0]    exact_q, exact_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic          accept;
  logic          max_load;
  logic          close;
  logic [CW-1:0] cnt_inc;

  assign accept   = in_valid & (state_q == S_ACCUM);
  assign cnt_inc  = cnt_q + CW'(accept);
  assign max_load = accept & ((cnt_q == '0) | (in_err > max_q));
  // flush closes only a non-empty frame, counting a same-cycle sample
  assign close    = (accept & (cnt_inc == CW'(FRAME_LEN)))
                  | (flush & (cnt_inc != '0));

  always_comb begin
    state_d = state_q;
    ov_d    = ov_q;
    sum_d   = sum_q;
    max_d   = max_q;
    maxa_d  = maxa_q;
    exact_d = exact_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_ACCUM: begin
        if (accept) begin
          cnt_d = cnt_inc;
          sum_d = sum_q + SW'(in_err);
          if (in_err == '0) begin
            exact_d = exact_q + CW'(1);
          end
          if (max_load) begin
            max_d  = in_err;
            maxa_d = in_a;
          end
        end
        if (close) begin
          state_d = S_HOLD;
          ov_d    = 1'b1;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_ACCUM;
          ov_d    = 1'b0;
          sum_d   = '0;
          max_d   = '0;
          maxa_d  = '0;
          exact_d = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_ACCUM;
        ov_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ACCUM;
      ov_q    <= 1'b0;
      sum_q   <= '0;
      max_q   <= '0;
      maxa_q  <= '0;
      exact_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ov_q    <= ov_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      maxa_q  <= maxa_d;
      exact_q <= exact_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = ov_q;
  assign sum_err   = sum_q;
  assign max_err   = max_q;
  assign max_err_a = maxa_q;
  assign exact_cnt = exact_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_sqrt_err_stats.sv
// Bench for sqrt_err_stats: FRAME_LEN=4 and FRAME_LEN=16 instances,
// frame-queue reference model plus directed literal expectations.
module tb_sqrt_err_stats;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv[2];
  logic       fl[2];
  logic       ordy[2];
  logic [7:0] ia[2];
  logic [7:0] ie[2];

  logic        irdy0, ov0, irdy1, ov1;
  logic [9:0]  sum0;
  logic [11:0] sum1;
  logic [7:0]  mx0, ma0, mx1, ma1;
  logic [2:0]  ex0, cn0;
  logic [4:0]  ex1, cn1;

  sqrt_err_stats #(.ASIZE(8), .ESIZE(8), .FRAME_LEN(4)) u_f4 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(irdy0),
    .in_a(ia[0]), .in_err(ie[0]), .flush(fl[0]),
    .out_valid(ov0), .out_ready(ordy[0]),
    .sum_err(sum0), .max_err(mx0), .max_err_a(ma0),
    .exact_cnt(ex0), .frame_cnt(cn0)
  );

  sqrt_err_stats #(.ASIZE(8), .ESIZE(8), .FRAME_LEN(16)) u_f16 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(irdy1),
    .in_a(ia[1]), .in_err(ie[1]), .flush(fl[1]),
    .out_valid(ov1), .out_ready(ordy[1]),
    .sum_err(sum1), .max_err(mx1), .max_err_a(ma1),
    .exact_cnt(ex1), .frame_cnt(cn1)
  );

  int d_rdy[2], d_ov[2], d_sum[2], d_max[2], d_maxa[2], d_ex[2], d_cn[2];
  always_comb begin
    d_rdy[0] = int'(irdy0); d_rdy[1] = int'(irdy1);
    d_ov[0]  = int'(ov0);   d_ov[1]  = int'(ov1);
    d_sum[0] = int'(sum0);  d_sum[1] = int'(sum1);
    d_max[0] = int'(mx0);   d_max[1] = int'(mx1);
    d_maxa[0] = int'(ma0);  d_maxa[1] = int'(ma1);
    d_ex[0]  = int'(ex0);   d_ex[1]  = int'(ex1);
    d_cn[0]  = int'(cn0);   d_cn[1]  = int'(cn1);
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(string n, int i, int got, int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[inst%0d] got=%0d expected=%0d t=%0t",
               n, i, got, exp, $time);
    end
  endtask

  // Reference model: samples of the open frame kept as a list; the
  // frame result is recomputed from that list when the frame closes.
  int  flen[2] = '{4, 16};
  int  fa[2][16];
  int  fe[2][16];
  int  fn[2];
  bit  hold[2];
  int  r_sum[2], r_max[2], r_maxa[2], r_ex[2], r_cn[2];
  bit  chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      chk_en <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        fn[i] = 0;
        hold[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!hold[i]) begin
          if (iv[i]) begin
            fa[i][fn[i]] = int'(ia[i]);
            fe[i][fn[i]] = int'(ie[i]);
            fn[i]++;
          end
          if ((iv[i] && fn[i] == flen[i]) || (fl[i] && fn[i] >= 1)) begin
            hold[i] = 1'b1;
            r_sum[i] = 0; r_ex[i] = 0; r_cn[i] = fn[i];
            r_max[i] = -1; r_maxa[i] = 0;
            for (int k = 0; k < fn[i]; k++) begin
              r_sum[i] += fe[i][k];
              if (fe[i][k] == 0) r_ex[i]++;
              if (fe[i][k] > r_max[i]) begin
                r_max[i] = fe[i][k];
                r_maxa[i] = fa[i][k];
              end
            end
          end
        end else if (ordy[i]) begin
          hold[i] = 1'b0;
          fn[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("in_ready", i, d_rdy[i], int'(!hold[i]));
        chk("out_valid", i, d_ov[i], int'(hold[i]));
        if (hold[i]) begin
          chk("sum_err", i, d_sum[i], r_sum[i]);
          chk("max_err", i, d_max[i], r_max[i]);
          chk("max_err_a", i, d_maxa[i], r_maxa[i]);
          chk("exact_cnt", i, d_ex[i], r_ex[i]);
          chk("frame_cnt", i, d_cn[i], r_cn[i]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int i, int a, int e, bit f);
    bit r;
    bit done;
    done = 1'b0;
    ia[i] = 8'(a);
    ie[i] = 8'(e);
    iv[i] = 1'b1;
    fl[i] = f;
    for (int c = 0; c < 100 && !done; c++) begin
      r = (d_rdy[i] != 0);
      tick();
      if (r) done = 1'b1;
    end
    if (!done) begin
      failures++;
      $display("FAIL accept_timeout[inst%0d] got=0 expected=1", i);
    end
    iv[i] = 1'b0;
    fl[i] = 1'b0;
  endtask

  task automatic expect_res(string n, int i, int s, int m,
                            int ma, int ex, int cn);
    chk({n, ".valid"}, i, d_ov[i], 1);
    chk({n, ".sum"}, i, d_sum[i], s);
    chk({n, ".max"}, i, d_max[i], m);
    chk({n, ".max_a"}, i, d_maxa[i], ma);
    chk({n, ".exact"}, i, d_ex[i], ex);
    chk({n, ".count"}, i, d_cn[i], cn);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; fl[i] = 1'b0; ordy[i] = 1'b1;
      ia[i] = '0;   ie[i] = '0;
    end
    rst = 1'b1;
    tick();
    tick();
    chk("rst.in_ready", 0, d_rdy[0], 1);
    chk("rst.out_valid", 0, d_ov[0], 0);
    chk("rst.sum", 0, d_sum[0], 0);
    rst = 1'b0;
    tick();

    push(0, 10, 1, 0); push(0, 15, 6, 0);
    push(0, 16, 0, 0); push(0, 255, 30, 0);
    expect_res("basic", 0, 37, 30, 255, 1, 4);
    tick();
    chk("basic.ready_back", 0, d_rdy[0], 1);
    chk("basic.valid_drop", 0, d_ov[0], 0);

    push(0, 15, 6, 0); push(0, 42, 6, 0);
    push(0, 4, 0, 0);  push(0, 9, 0, 0);
    expect_res("tie", 0, 12, 6, 15, 2, 4);

    push(0, 24, 8, 0); push(0, 36, 0, 0); push(0, 35, 10, 1);
    expect_res("flush", 0, 18, 10, 35, 1, 3);
    tick();
    fl[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("empty_flush.valid", 0, d_ov[0], 0);
    end
    fl[0] = 1'b0;

    ordy[0] = 1'b0;
    push(0, 1, 0, 0); push(0, 2, 1, 0);
    push(0, 3, 2, 0); push(0, 5, 1, 0);
    expect_res("bp", 0, 4, 2, 3, 1, 4);
    ia[0] = 8'd7; ie[0] = 8'd3; iv[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp.in_ready", 0, d_rdy[0], 0);
      chk("bp.sum_hold", 0, d_sum[0], 4);
      chk("bp.cnt_hold", 0, d_cn[0], 4);
    end
    ordy[0] = 1'b1;
    push(0, 7, 3, 0); push(0, 8, 4, 0);
    push(0, 9, 0, 0); push(0, 10, 1, 0);
    expect_res("bp_next", 0, 8, 4, 8, 1, 4);
    tick();

    push(0, 50, 1, 0); push(0, 60, 11, 0);
    rst = 1'b1;
    tick();
    chk("mid_rst.in_ready", 0, d_rdy[0], 1);
    chk("mid_rst.out_valid", 0, d_ov[0], 0);
    chk("mid_rst.sum", 0, d_sum[0], 0);
    chk("mid_rst.max", 0, d_max[0], 0);
    chk("mid_rst.max_a", 0, d_maxa[0], 0);
    chk("mid_rst.exact", 0, d_ex[0], 0);
    chk("mid_rst.count", 0, d_cn[0], 0);
    rst = 1'b0;
    push(0, 1, 0, 0); push(0, 4, 0, 0);
    push(0, 9, 0, 0); push(0, 16, 0, 0);
    expect_res("post_rst", 0, 0, 0, 1, 4, 4);
    tick();

    for (int k = 0; k < 16; k++) push(1, 255, 30, 0);
    expect_res("full30", 1, 480, 30, 255, 0, 16);
    for (int k = 0; k < 16; k++) push(1, 255, 255, 0);
    expect_res("full255", 1, 4080, 255, 255, 0, 16);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
